// File: rtl/dec_8_accum.sv
// Accumulates 3-bit encoded bit indices into an 8-bit request mask, one frame at a time.
// Optional duplicate-index flag on err is compiled in with `define DEC_DUP_ERR_EN.
module dec_8_accum #(
    parameter int MAX_CODES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] Y,
    input  logic       V,
    input  logic       last,
    output logic       in_ready,
    output logic [7:0] D,
    output logic [7:0] A,
    output logic       A_valid,
    input  logic       A_ready,
    output logic       err,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_C = 4'(MAX_CODES);

    state_t     state_q;
    logic [7:0] mask_q, mask_d;
    logic [7:0] d_q, d_d;
    logic [3:0] count_q, count_d;
    logic [3:0] count_inc;
    logic [7:0] onehot;
    logic       in_ready_q;
    logic       a_valid_q;
    logic       accept;
    logic       close;
    logic       xfer;

    // Handshakes: a code is taken on a rising edge with V=1 while not holding;
    // a frame leaves on a rising edge with A_valid=1 and A_ready=1.
    always_comb begin
        onehot    = 8'd1 << Y;
        accept    = V && (state_q != HOLD);
        xfer      = (state_q == HOLD) && A_ready;
        count_inc = (state_q == IDLE) ? 4'd1 : count_q + 4'd1;
        close     = last || (count_inc == MAX_C);
        mask_d    = mask_q;
        count_d   = count_q;
        d_d       = d_q;
        if (accept) begin
            mask_d  = (state_q == IDLE) ? onehot : (mask_q | onehot);
            count_d = count_inc;
            d_d     = onehot;
        end else if (xfer) begin
            mask_d  = 8'd0;
            count_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= 8'd0;
            count_q    <= 4'd0;
            d_q        <= 8'd0;
            in_ready_q <= 1'b1;
            a_valid_q  <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
            d_q     <= d_d;
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (close) begin
                            state_q    <= HOLD;
                            in_ready_q <= 1'b0;
                            a_valid_q  <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (A_ready) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        a_valid_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    a_valid_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEC_DUP_ERR_EN
    logic err_q;

    // Only ACCUM can see a duplicate; IDLE always starts from an empty mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (xfer) begin
            err_q <= 1'b0;
        end else if (accept && (state_q == ACCUM) && ((mask_q & onehot) != 8'd0)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign A_valid  = a_valid_q;
    assign A        = mask_q;
    assign D        = d_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_dec_8_accum.sv
// Bench for dec_8_accum: directed vector table, hand-written corner sequences and
// randomized traffic against a frame-level reference model with a transfer scoreboard.
module tb_dec_8_accum;

    localparam int MAXC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Y;
    logic       V;
    logic       last;
    logic       in_ready;
    logic [7:0] D;
    logic [7:0] A;
    logic       A_valid;
    logic       A_ready;
    logic       err;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    dec_8_accum #(.MAX_CODES(MAXC)) dut (
        .clk     (clk),
        .rst     (rst),
        .Y       (Y),
        .V       (V),
        .last    (last),
        .in_ready(in_ready),
        .D       (D),
        .A       (A),
        .A_valid (A_valid),
        .A_ready (A_ready),
        .err     (err),
        .state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2:0] m_frame[$];
    logic       m_hold;
    logic [7:0] m_d;
    logic       m_err;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] frame_mask();
        logic [7:0] r;
        logic [7:0] one;
        r   = 8'd0;
        one = 8'd1;
        foreach (m_frame[i]) r = r | (one << m_frame[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_frame.delete();
        exp_q.delete();
        m_hold = 1'b0;
        m_d    = 8'd0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] y, input logic lst, input logic ardy);
        logic [7:0] one;
        one = 8'd1;
        if (m_hold) begin
            if (ardy) begin
                m_hold = 1'b0;
                m_frame.delete();
                m_err  = 1'b0;
            end
        end else if (v) begin
`ifdef DEC_DUP_ERR_EN
            foreach (m_frame[i]) if (m_frame[i] == y) m_err = 1'b1;
`endif
            m_frame.push_back(y);
            m_d = one << y;
            if (lst || (m_frame.size() == MAXC)) begin
                m_hold = 1'b1;
                exp_q.push_back(frame_mask());
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_A", A, frame_mask());
        chk("model_D", D, m_d);
        chk("model_A_valid", {7'd0, A_valid}, {7'd0, m_hold});
        chk("model_in_ready", {7'd0, in_ready}, {7'd0, !m_hold});
        chk("model_err", {7'd0, err}, {7'd0, m_err});
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic v, input logic [2:0] y, input logic lst, input logic ardy);
        logic [7:0] e;
        V = v; Y = y; last = lst; A_ready = ardy;
        if (A_valid && ardy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_frame", A, 8'hxx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_frame", A, e);
            end
        end
        @(posedge clk);
        model_edge(v, y, lst, ardy);
        #1;
        check_model();
    endtask

    task automatic async_reset();
        V = 1'b0; Y = 3'd0; last = 1'b0; A_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_A", A, 8'h00);
        chk("rst_D", D, 8'h00);
        chk("rst_A_valid", {7'd0, A_valid}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [2:0] y;
        logic       lst;
        logic       ardy;
        logic [7:0] a;
        logic [7:0] d;
        logic       av;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [2:0] y, input logic lst, input logic ardy,
                           input logic [7:0] a, input logic [7:0] d, input logic av);
        vec_t t;
        t.v = v; t.y = y; t.lst = lst; t.ardy = ardy; t.a = a; t.d = d; t.av = av;
        vecs.push_back(t);
    endtask

    logic err_exp;

    initial begin
        rst = 1'b1;
        V = 1'b0; Y = 3'd0; last = 1'b0; A_ready = 1'b0;
        model_reset();
        #2;
        chk("por_A", A, 8'h00);
        chk("por_D", D, 8'h00);
        chk("por_A_valid", {7'd0, A_valid}, 8'h00);
        chk("por_in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single-code frame, then transfer
        add_vec(1, 3'd3, 1, 0, 8'h08, 8'h08, 1);
        add_vec(0, 3'd0, 0, 1, 8'h00, 8'h08, 0);
        // three-code frame closed by last
        add_vec(1, 3'd0, 0, 0, 8'h01, 8'h01, 0);
        add_vec(1, 3'd5, 0, 0, 8'h21, 8'h20, 0);
        add_vec(1, 3'd7, 1, 0, 8'hA1, 8'h80, 1);
        add_vec(0, 3'd0, 0, 1, 8'h00, 8'h80, 0);
        // eight codes close the frame by count
        add_vec(1, 3'd0, 0, 0, 8'h01, 8'h01, 0);
        add_vec(1, 3'd1, 0, 0, 8'h03, 8'h02, 0);
        add_vec(1, 3'd2, 0, 0, 8'h07, 8'h04, 0);
        add_vec(1, 3'd3, 0, 0, 8'h0F, 8'h08, 0);
        add_vec(1, 3'd4, 0, 0, 8'h1F, 8'h10, 0);
        add_vec(1, 3'd5, 0, 0, 8'h3F, 8'h20, 0);
        add_vec(1, 3'd6, 0, 0, 8'h7F, 8'h40, 0);
        add_vec(1, 3'd7, 0, 0, 8'hFF, 8'h80, 1);
        add_vec(0, 3'd0, 0, 1, 8'h00, 8'h80, 0);
        // A_ready outside HOLD is ignored; ACCUM waits on V=0
        add_vec(0, 3'd0, 0, 1, 8'h00, 8'h80, 0);
        add_vec(1, 3'd2, 0, 1, 8'h04, 8'h04, 0);
        add_vec(0, 3'd2, 0, 0, 8'h04, 8'h04, 0);
        add_vec(0, 3'd6, 1, 1, 8'h04, 8'h04, 0);
        add_vec(1, 3'd2, 1, 0, 8'h04, 8'h04, 1);
        add_vec(0, 3'd0, 0, 1, 8'h00, 8'h04, 0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].y, vecs[i].lst, vecs[i].ardy);
            chk("vec_A", A, vecs[i].a);
            chk("vec_D", D, vecs[i].d);
            chk("vec_A_valid", {7'd0, A_valid}, {7'd0, vecs[i].av});
        end

        // HOLD ignores V while A_ready=0
        step(1, 3'd1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd2, 0, 0);
            chk("hold_A", A, 8'h02);
            chk("hold_in_ready", {7'd0, in_ready}, 8'h00);
            chk("hold_D", D, 8'h02);
        end
        step(0, 3'd0, 0, 1);
        chk("hold_release_A", A, 8'h00);
        step(1, 3'd2, 1, 0);
        chk("after_hold_A", A, 8'h04);
        step(0, 3'd0, 0, 1);

        // duplicate index
`ifdef DEC_DUP_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        step(1, 3'd4, 0, 0);
        step(1, 3'd4, 0, 0);
        step(1, 3'd4, 1, 0);
        chk("dup_A", A, 8'h10);
        chk("dup_err", {7'd0, err}, {7'd0, err_exp});
        step(0, 3'd0, 0, 1);
        chk("dup_err_cleared", {7'd0, err}, 8'h00);

        // asynchronous reset mid-frame
        step(1, 3'd1, 0, 0);
        async_reset();
        step(1, 3'd6, 1, 0);
        chk("post_rst_A", A, 8'h40);
        step(0, 3'd0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
